// File: rtl/instr_fetch_unit.sv
// Fetch stage: issues word reads, buffers {pc, instr} in a prefetch FIFO and hands them to decode.
// Define IFU_FETCH_BYPASS_EN to forward a returning word straight to decode when the FIFO is empty.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0,
   parameter int          DEPTH    = 4
) (
   input  logic        clk,
   input  logic        rst,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   input  logic        in_redirect_valid,
   input  logic [31:0] in_redirect_pc,
   input  logic        in_ready,
   output logic        out_valid,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW:0]  DEPTH_L = (CW + 1)'(DEPTH);
   localparam logic [31:0]  PC_MASK = ~32'h3;

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_DROP = 2'd2} state_t;

   state_t          state_q, state_d;
   logic [31:0]     fetch_pc_q, fetch_pc_d;
   logic [31:0]     req_addr_q, req_addr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [31:0]     fifo_pc_q    [DEPTH];
   logic [31:0]     fifo_instr_q [DEPTH];

   logic            head_valid_s, bypass_s, pop_s, push_s, room_s;
   logic [CW:0]     level_s;
   logic [31:0]     pc_inc_s;

   assign head_valid_s = (count_q != {CW{1'b0}});
`ifdef IFU_FETCH_BYPASS_EN
   assign bypass_s = (state_q == S_WAIT) && !head_valid_s && mem_ack && in_ready && !in_redirect_valid;
`else
   assign bypass_s = 1'b0;
`endif
   assign pop_s    = head_valid_s && in_ready && !in_redirect_valid;
   assign push_s   = (state_q == S_WAIT) && mem_ack && !in_redirect_valid && !bypass_s;
   // Occupancy after this cycle's pop/push decides whether another request may go out.
   assign level_s  = {1'b0, count_q} - (CW + 1)'(pop_s) + (CW + 1)'(push_s);
   assign room_s   = (level_s < DEPTH_L);
   assign pc_inc_s = fetch_pc_q + 32'd4;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         fetch_pc_q <= RESET_PC & PC_MASK;
         req_addr_q <= 32'h0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         req_addr_q <= req_addr_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      req_addr_d = req_addr_q;
      if (in_redirect_valid) begin
         // An outstanding read must still complete; DROP swallows its data.
         fetch_pc_d = in_redirect_pc & PC_MASK;
         case (state_q)
            S_IDLE:  state_d = S_IDLE;
            S_WAIT:  state_d = mem_ack ? S_IDLE : S_DROP;
            S_DROP:  state_d = mem_ack ? S_IDLE : S_DROP;
            default: state_d = S_IDLE;
         endcase
      end else begin
         case (state_q)
            S_IDLE: begin
               if (room_s) begin
                  state_d    = S_WAIT;
                  req_addr_d = fetch_pc_q;
               end else begin
                  state_d = S_IDLE;
               end
            end
            S_WAIT: begin
               if (mem_ack) begin
                  fetch_pc_d = pc_inc_s;
                  if (room_s) begin
                     state_d    = S_WAIT;
                     req_addr_d = pc_inc_s;
                  end else begin
                     state_d = S_IDLE;
                  end
               end else begin
                  state_d = S_WAIT;
               end
            end
            S_DROP:  state_d = mem_ack ? S_IDLE : S_DROP;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      mem_req  = (state_q != S_IDLE);
      mem_addr = req_addr_q;
      if (bypass_s) begin
         out_valid = 1'b1;
         out_instr = mem_rdata;
         out_pc    = req_addr_q;
      end else begin
         out_valid = head_valid_s;
         out_instr = fifo_instr_q[rd_ptr_q];
         out_pc    = fifo_pc_q[rd_ptr_q];
      end
   end

   always_comb begin
      if (in_redirect_valid) begin
         count_d  = {CW{1'b0}};
         rd_ptr_d = {AW{1'b0}};
         wr_ptr_d = {AW{1'b0}};
      end else begin
         count_d  = level_s[CW-1:0];
         rd_ptr_d = rd_ptr_q + AW'(pop_s);
         wr_ptr_d = wr_ptr_q + AW'(push_s);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q  <= {CW{1'b0}};
         rd_ptr_q <= {AW{1'b0}};
         wr_ptr_q <= {AW{1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            fifo_pc_q[i]    <= 32'h0;
            fifo_instr_q[i] <= 32'h0;
         end
      end else begin
         count_q  <= count_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         if (push_s) begin
            fifo_pc_q[wr_ptr_q]    <= req_addr_q;
            fifo_instr_q[wr_ptr_q] <= mem_rdata;
         end
      end
   end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit (RESET_PC=32'h100, DEPTH=4); outputs sampled 1 time unit after each rising edge.
module tb_instr_fetch_unit;
   localparam logic [31:0] K = 32'hA5A5_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        in_redirect_valid;
   logic [31:0] in_redirect_pc;
   logic        in_ready;
   logic        out_valid;
   logic [31:0] out_instr;
   logic [31:0] out_pc;

   int checks   = 0;
   int failures = 0;

   instr_fetch_unit #(.RESET_PC(32'h100), .DEPTH(4)) dut (
      .clk               (clk),
      .rst               (rst),
      .mem_req           (mem_req),
      .mem_addr          (mem_addr),
      .mem_ack           (mem_ack),
      .mem_rdata         (mem_rdata),
      .in_redirect_valid (in_redirect_valid),
      .in_redirect_pc    (in_redirect_pc),
      .in_ready          (in_ready),
      .out_valid         (out_valid),
      .out_instr         (out_instr),
      .out_pc            (out_pc)
   );

   always #5 clk = ~clk;

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic step(input logic ack, input logic [31:0] rdata, input logic redir, input logic [31:0] rpc);
      mem_ack           = ack;
      mem_rdata         = rdata;
      in_redirect_valid = redir;
      in_redirect_pc    = rpc;
      @(posedge clk);
      #1;
      mem_ack           = 1'b0;
      mem_rdata         = 32'h0;
      in_redirect_valid = 1'b0;
      in_redirect_pc    = 32'h0;
   endtask

   // Memory that acks every outstanding request one cycle after it appears.
   task automatic step_auto();
      step(mem_req, mem_req ? (mem_addr ^ K) : 32'h0, 1'b0, 32'h0);
   endtask

   initial begin
      #50000;
      $display("FAIL timeout");
      $fatal(1, "bench timeout");
   end

   initial begin
      rst = 1'b1; mem_ack = 1'b0; mem_rdata = 32'h0;
      in_redirect_valid = 1'b0; in_redirect_pc = 32'h0; in_ready = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk1 ("rst_mem_req",   mem_req,   1'b0);
      chk32("rst_mem_addr",  mem_addr,  32'h0);
      chk1 ("rst_out_valid", out_valid, 1'b0);
      chk32("rst_out_instr", out_instr, 32'h0);
      chk32("rst_out_pc",    out_pc,    32'h0);

      // streaming from RESET_PC
      rst = 1'b0; in_ready = 1'b1;
      step_auto();
      chk1 ("t1_req",       mem_req,   1'b1);
      chk32("t1_addr",      mem_addr,  32'h100);
      chk1 ("t1_valid0",    out_valid, 1'b0);
      step_auto();
      chk1 ("t1_valid1",    out_valid, 1'b1);
      chk32("t1_pc0",       out_pc,    32'h100);
      chk32("t1_instr0",    out_instr, 32'hA5A5_0100);
      for (int k = 1; k <= 3; k++) begin
         step_auto();
         chk1 ("t1_valid_n", out_valid, 1'b1);
         chk32("t1_pc_n",    out_pc,    32'h100 + 32'(4 * k));
         chk32("t1_instr_n", out_instr, (32'h100 + 32'(4 * k)) ^ K);
      end

      // reset mid-transfer, then fill the FIFO with decode stalled
      rst = 1'b1;
      #1;
      chk1 ("t2_async_req",  mem_req,   1'b0);
      chk1 ("t2_async_vld",  out_valid, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0; in_ready = 1'b0;
      for (int k = 0; k < 5; k++) step_auto();
      chk1 ("t2_full_req",   mem_req,   1'b0);
      chk1 ("t2_full_vld",   out_valid, 1'b1);
      chk32("t2_full_pc",    out_pc,    32'h100);
      step_auto();
      chk1 ("t2_hold_req",   mem_req,   1'b0);
      chk32("t2_hold_pc",    out_pc,    32'h100);
      in_ready = 1'b1;
      step_auto();
      chk32("t2_pop1_pc",    out_pc,    32'h104);
      chk1 ("t2_resume_req", mem_req,   1'b1);
      chk32("t2_resume_adr", mem_addr,  32'h110);
      step_auto();
      chk32("t2_pop2_pc",    out_pc,    32'h108);
      step_auto();
      chk32("t2_pop3_pc",    out_pc,    32'h10C);
      chk32("t2_pop3_instr", out_instr, 32'hA5A5_010C);
      step_auto();
      chk32("t2_next_pc",    out_pc,    32'h110);
      chk32("t2_next_instr", out_instr, 32'hA5A5_0110);

      // redirect while a read is outstanding
      step(1'b0, 32'h0, 1'b1, 32'h0000_2002);
      chk1 ("t3_flush_vld",  out_valid, 1'b0);
      chk1 ("t3_drop_req",   mem_req,   1'b1);
      chk32("t3_drop_addr",  mem_addr,  32'h11C);
      step(1'b0, 32'h0, 1'b0, 32'h0);
      step(1'b0, 32'h0, 1'b0, 32'h0);
      chk1 ("t3_wait_vld",   out_valid, 1'b0);
      step(1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0);
      chk1 ("t3_dropped_vld", out_valid, 1'b0);
      chk1 ("t3_dropped_req", mem_req,   1'b0);
      step(1'b0, 32'h0, 1'b0, 32'h0);
      chk1 ("t3_new_req",    mem_req,   1'b1);
      chk32("t3_new_addr",   mem_addr,  32'h2000);
      chk1 ("t3_new_vld",    out_valid, 1'b0);
      step(1'b1, 32'h1111_2000, 1'b0, 32'h0);
      chk1 ("t3_ret_vld",    out_valid, 1'b1);
      chk32("t3_ret_pc",     out_pc,    32'h2000);
      chk32("t3_ret_instr",  out_instr, 32'h1111_2000);

      // redirect coinciding with ack and pop, two entries buffered
      in_ready = 1'b0;
      step(1'b1, 32'h1111_2004, 1'b0, 32'h0);
      chk32("t4_stall_pc",   out_pc,    32'h2000);
      chk32("t4_stall_addr", mem_addr,  32'h2008);
      in_ready = 1'b1;
      step(1'b1, 32'h1111_2008, 1'b1, 32'h0000_3000);
      chk1 ("t4_flush_vld",  out_valid, 1'b0);
      chk1 ("t4_idle_req",   mem_req,   1'b0);
      step(1'b0, 32'h0, 1'b0, 32'h0);
      chk1 ("t4_new_req",    mem_req,   1'b1);
      chk32("t4_new_addr",   mem_addr,  32'h3000);
      chk1 ("t4_new_vld",    out_valid, 1'b0);

      // address wrap at the top of memory
      step(1'b0, 32'h0, 1'b1, 32'hFFFF_FFFE);
      chk32("t5_drop_addr",  mem_addr,  32'h3000);
      step(1'b1, 32'h0BAD_0BAD, 1'b0, 32'h0);
      chk1 ("t5_drop_vld",   out_valid, 1'b0);
      step(1'b0, 32'h0, 1'b0, 32'h0);
      chk32("t5_top_addr",   mem_addr,  32'hFFFF_FFFC);
      step(1'b1, 32'hCAFE_0001, 1'b0, 32'h0);
      chk32("t5_wrap_addr",  mem_addr,  32'h0);
      chk32("t5_top_pc",     out_pc,    32'hFFFF_FFFC);
      chk32("t5_top_instr",  out_instr, 32'hCAFE_0001);

      // ack into an empty FIFO: same-cycle only with the bypass
      step(1'b0, 32'h0, 1'b0, 32'h0);
      chk1 ("t6_empty_vld",  out_valid, 1'b0);
      mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
      #1;
`ifdef IFU_FETCH_BYPASS_EN
      chk1 ("t6_ack_vld",    out_valid, 1'b1);
      chk32("t6_ack_instr",  out_instr, 32'h1234_5678);
`else
      chk1 ("t6_ack_vld",    out_valid, 1'b0);
`endif
      @(posedge clk); #1;
      mem_ack = 1'b0; mem_rdata = 32'h0;
`ifdef IFU_FETCH_BYPASS_EN
      chk1 ("t6_after_vld",  out_valid, 1'b0);
`else
      chk1 ("t6_after_vld",  out_valid, 1'b1);
      chk32("t6_after_instr", out_instr, 32'h1234_5678);
      chk32("t6_after_pc",   out_pc,    32'h0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
